// File: rtl/mmio_io_decode.sv
// Hack CPU data-port decoder: RAM at 0-8191, buttons/LEDs/press latch at 8192-8194, uniform 1-cycle read latency.
// Define MMIO_DEBOUNCE_EN to build per-button debounce counters; otherwise buttons are only synchronised.
module mmio_io_decode #(
  parameter int BUT_W           = 4,
  parameter int LED_W           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      address,
  input  logic [15:0]      dataW,
  input  logic             load,
  output logic [15:0]      dataR,
  output logic             ram_load,
  input  logic [15:0]      ram_dataR,
  input  logic [BUT_W-1:0] but,
  output logic [LED_W-1:0] led
);

  localparam logic [15:0] ADDR_BUT   = 16'd8192;
  localparam logic [15:0] ADDR_LED   = 16'd8193;
  localparam logic [15:0] ADDR_PRESS = 16'd8194;

  typedef enum logic {SEL_IO = 1'b0, SEL_RAM = 1'b1} sel_t;

  if (DEBOUNCE_CYCLES < 2 || BUT_W < 1 || BUT_W > 16 || LED_W < 1 || LED_W > 16) begin : g_param_check
    $error("mmio_io_decode: parameter out of range");
  end

  sel_t             sel_q;
  logic [15:0]      io_q;
  logic [15:0]      io_rd;
  logic             ram_sel;
  logic             but_sel;
  logic             led_sel;
  logic             press_sel;
  logic [BUT_W-1:0] sync1;
  logic [BUT_W-1:0] sync2;
  logic [BUT_W-1:0] stable;
  logic [BUT_W-1:0] stable_nxt;
  logic [BUT_W-1:0] press;
  logic [BUT_W-1:0] press_clr;
  logic             unused_data_bits;

  assign ram_sel   = (address[15:13] == 3'b000);
  assign but_sel   = (address == ADDR_BUT);
  assign led_sel   = (address == ADDR_LED);
  assign press_sel = (address == ADDR_PRESS);

  // Combinational so the RAM can never be written through an alias above 8191.
  assign ram_load  = load & ram_sel;
  assign press_clr = (load && press_sel) ? dataW[BUT_W-1:0] : '0;

  assign unused_data_bits = ^dataW;

  always_comb begin
    io_rd = '0;
    if (but_sel)
      io_rd[BUT_W-1:0] = stable;
    else if (led_sel)
      io_rd[LED_W-1:0] = led;
    else if (press_sel)
      io_rd[BUT_W-1:0] = press;
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt     [BUT_W];
  logic [CNT_W-1:0] cnt_nxt [BUT_W];

  // A new level must persist for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_comb begin
    for (int i = 0; i < BUT_W; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX)
          stable_nxt[i] = sync2[i];
        else
          cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUT_W; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BUT_W; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end
`else
  assign stable_nxt = sync2;
`endif

  // Set on a stable rising edge wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
    end else begin
      sync1  <= but;
      sync2  <= sync1;
      stable <= stable_nxt;
      press  <= (press & ~press_clr) | (stable_nxt & ~stable);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      led <= '0;
    else if (load && led_sel)
      led <= dataW[LED_W-1:0];
  end

  // io_q samples pre-write state, giving read-before-write like the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_IO;
      io_q  <= '0;
    end else begin
      sel_q <= ram_sel ? SEL_RAM : SEL_IO;
      io_q  <= io_rd;
    end
  end

  assign dataR = (sel_q == SEL_RAM) ? ram_dataR : io_q;

endmodule

// File: tb/tb_mmio_io_decode.sv
// Directed self-checking bench for mmio_io_decode with DEBOUNCE_CYCLES=4.
// Expectations follow MMIO_DEBOUNCE_EN when the macro is defined for the build.
module tb_mmio_io_decode;

  localparam int BUT_W           = 4;
  localparam int LED_W           = 4;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef MMIO_DEBOUNCE_EN
  localparam int RISE_LAT = DEBOUNCE_CYCLES + 2;
`else
  localparam int RISE_LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [15:0]      address = '0;
  logic [15:0]      dataW = '0;
  logic             load = 1'b0;
  logic [15:0]      dataR;
  logic             ram_load;
  logic [15:0]      ram_dataR;
  logic [BUT_W-1:0] but = '0;
  logic [LED_W-1:0] led;
  logic [15:0]      mem [0:8191];
  int               total = 0;
  int               bad = 0;

  mmio_io_decode #(
    .BUT_W(BUT_W),
    .LED_W(LED_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .dataW(dataW),
    .load(load),
    .dataR(dataR),
    .ram_load(ram_load),
    .ram_dataR(ram_dataR),
    .but(but),
    .led(led)
  );

  always #5 clk = ~clk;

  // Registered read-before-write RAM, addressed directly by the CPU bus.
  always @(posedge clk) begin
    if (ram_load)
      mem[address[12:0]] <= dataW;
    ram_dataR <= mem[address[12:0]];
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic ld);
    @(negedge clk);
    address = a;
    dataW   = d;
    load    = ld;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  task automatic readWord(input logic [15:0] a, input logic [15:0] expected, input string tag);
    applyStimulus(a, 16'h0000, 1'b0);
    tick(1);
    checkOutput(tag, dataR, expected);
  endtask

  initial begin
    $display("[TB] start, RISE_LAT=%0d", RISE_LAT);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_dataR", dataR, 16'h0000);
    checkOutput("reset_led", 16'(led), 16'h0000);
    checkOutput("reset_ram_load", 16'(ram_load), 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'd100, 16'h1234, 1'b1);
    #1 checkOutput("ram_load_wr", 16'(ram_load), 16'h0001);
    applyStimulus(16'd100, 16'h0000, 1'b0);
    #1 checkOutput("ram_load_rd", 16'(ram_load), 16'h0000);
    tick(1);
    checkOutput("ram_read", dataR, 16'h1234);
    applyStimulus(16'd9000, 16'hBEEF, 1'b1);
    #1 checkOutput("ram_load_9000", 16'(ram_load), 16'h0000);
    readWord(16'd9000, 16'h0000, "unmapped_read");

    applyStimulus(16'd8193, 16'hFFF5, 1'b1);
    tick(1);
    checkOutput("led_after_wr", 16'(led), 16'h0005);
    checkOutput("led_read_during_wr", dataR, 16'h0000);
    readWord(16'd8193, 16'h0005, "led_read");
    applyStimulus(16'd8192, 16'hFFFF, 1'b1);
    tick(1);
    readWord(16'd8192, 16'h0000, "but_write_ignored");
    applyStimulus(16'd8195, 16'h0000, 1'b1);
    tick(1);
    checkOutput("led_unmapped_wr", 16'(led), 16'h0005);
    readWord(16'd8193, 16'h0005, "led_read_again");

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", 16'(led), 16'h0000);
    checkOutput("async_reset_dataR", dataR, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MMIO_DEBOUNCE_EN
    applyStimulus(16'd8192, 16'h0000, 1'b0);
    but[0] = 1'b1;
    repeat (3) @(negedge clk);
    but[0] = 1'b0;
    tick(8);
    checkOutput("short_pulse_but", dataR, 16'h0000);
    readWord(16'd8194, 16'h0000, "short_pulse_press");
`endif

    applyStimulus(16'd8192, 16'h0000, 1'b0);
    but[0] = 1'b1;
    tick(RISE_LAT);
    checkOutput("but0_not_yet", dataR, 16'h0000);
    tick(1);
    checkOutput("but0_visible", dataR, 16'h0001);
    readWord(16'd8194, 16'h0001, "press0_set");

    applyStimulus(16'd8192, 16'h0000, 1'b0);
    but[1] = 1'b1;
    tick(RISE_LAT + 1);
    checkOutput("but01_visible", dataR, 16'h0003);
    readWord(16'd8194, 16'h0003, "press01_set");

    applyStimulus(16'd8194, 16'h0001, 1'b1);
    tick(1);
    readWord(16'd8194, 16'h0002, "press_w1c_bit0");
    applyStimulus(16'd8194, 16'h0002, 1'b1);
    tick(1);
    readWord(16'd8194, 16'h0000, "press_w1c_bit1");

    applyStimulus(16'd100, 16'h0000, 1'b0);
    but[1] = 1'b0;
    tick(RISE_LAT + 2);
    readWord(16'd8192, 16'h0001, "but1_released");
    readWord(16'd8194, 16'h0000, "press_no_set_on_fall");

    applyStimulus(16'd100, 16'h0000, 1'b0);
    but[1] = 1'b1;
    repeat (RISE_LAT - 1) @(posedge clk);
    applyStimulus(16'd8194, 16'h0002, 1'b1);
    tick(1);
    readWord(16'd8194, 16'h0002, "collision_set_wins");

    applyStimulus(16'd100, 16'h0000, 1'b0);
    but[3] = 1'b1;
    @(negedge clk);
    but[3] = 1'b0;
    tick(RISE_LAT + 3);
`ifdef MMIO_DEBOUNCE_EN
    readWord(16'd8194, 16'h0002, "glitch_press");
`else
    readWord(16'd8194, 16'h000A, "glitch_press");
`endif
    readWord(16'd8192, 16'h0003, "but_after_glitch");
    checkOutput("led_after_reset_run", 16'(led), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_io_decode.md
Name: mmio_io_decode

Overview:
- Sits between the Hack CPU data port and the 8Kx16 RAM block.
- Decodes the 16-bit data address. Routes 0-8191 to RAM. Implements the memory-mapped IO words: 8192 buttons, 8193 LEDs, 8194 button-press latch.
- Synchronises and debounces board buttons and drives the board LEDs.
- Returns read data with the same 1-cycle latency as RAM, so the CPU sees one uniform memory.

Parameters:
- BUT_W, 4, number of button inputs (1-16).
- LED_W, 4, number of LED outputs (1-16).
- DEBOUNCE_CYCLES, 250000, cycles an input must hold a new level before it is accepted (10 ms at 25 MHz). Must be ≥2. Counter width = clog2(DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- address  in  16  CPU data address
- dataW  in  16  CPU write data
- load  in  1  CPU write strobe
- dataR  out  16  read data to CPU, valid 1 cycle after address
- ram_load  out  1  write strobe to RAM
- ram_dataR  in  16  registered read data from RAM (RAM drives address[12:0] and dataW directly)
- but  in  BUT_W  raw asynchronous button pins, active-high
- led  out  LED_W  LED drive, active-high

Behaviour:
- Decode:
  - address[15:13]==0 selects RAM.
  - 8192 selects BUT (read-only).
  - 8193 selects LED (R/W).
  - 8194 selects PRESS (read, write-1-to-clear).
  - Any other address is unmapped.
- ram_load = load AND RAM selected. This output is combinational, so RAM aliasing above 8191 can never be written.
- Read path:
  - At each posedge, sel_q <= decoded selection and io_q <= IO read value for the current address.
  - dataR = ram_dataR if sel_q==RAM, else io_q.
  - Latency is exactly 1 cycle for every address.
  - Unmapped reads return 0.
  - IO values are zero-extended to 16 bits.
- Read during write to the same IO word: returns the old value. The write lands at the same edge and appears on the next read. This matches RAM read-before-write.
- Button path:
  - 2-flop synchroniser per bit, giving sync.
  - Per-bit debounce counter:
    - sync==stable: counter <= 0.
    - sync!=stable: counter increments.
    - counter==DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- BUT read value = stable.
- PRESS latch:
  - A bit sets on a stable 0->1 transition.
  - A write to 8194 clears each bit where dataW bit is 1.
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- LED: write to 8193 loads led <= dataW[LED_W-1:0]. Upper bits are ignored.
- Writes to 8192 and unmapped addresses are ignored, with no side effects.
- Reset (asynchronous assert, synchronous use after release):
  - led=0, PRESS=0, stable=0, sync=0, counters=0.
  - sel_q=IO, io_q=0, so dataR=0 until the first post-reset cycle.
  - Reset mid-debounce discards the partial count.
  - A button held through reset release is seen as a press after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
- Macro MMIO_DEBOUNCE_EN.
- Defined: debounce counters exist exactly as described above.
- Undefined:
  - No counters are instantiated.
  - stable <= sync every cycle, so a button is visible 3 cycles after the pin changes (2 sync flops + stable register).
  - PRESS latching and all other behaviour are unchanged.
  - Intended for fast simulation and for boards with hardware debounce.

Test Plan:
- Apply the following with DEBOUNCE_CYCLES=4:
  1. RAM pass-through: write 0x1234 at address 100, then read 100. Expect ram_load=1 only in the write cycle, and dataR=0x1234 one cycle after the read address. Write at 9000: expect ram_load=0, and reading 9000 returns 0.
  2. LED register: write 0xFFF5 at 8193. Expect led=4'b0101 after that edge; reading 8193 returns 0x0005. Reset mid-run: expect led=0 immediately, asynchronously, and dataR=0.
  3. Debounce: pulse but[0] high for 3 cycles. Expect BUT and PRESS to stay 0. Hold but[0] high for ≥7 cycles. Expect reading 8192 to return 0x0001, and 8194 to return 0x0001.
  4. W1C and collision:
     - With PRESS=0x0003, write 0x0001 to 8194; expect a read of 0x0002.
     - Force a new 0->1 press of bit1 in the same cycle as a write of 0x0002 to 8194; expect bit1 still set.
  5. Macro off: with MMIO_DEBOUNCE_EN undefined, raise but[2]. Expect reading 8192 to return 0x0004 once 3 cycles have elapsed, and a 1-cycle glitch to set PRESS bit2.
